// File: rtl/selftrigger_channel_arbiter_if.sv
// Readout request handshake between the self-trigger arbiter and the record builder.
// req_ts is present only when SELFTRIG_TIMESTAMP_EN is defined.
interface selftrigger_channel_arbiter_if #(
    parameter int NUM_CH = 8
`ifdef SELFTRIG_TIMESTAMP_EN
    ,parameter int TS_W = 64
`endif
);
    localparam int CH_W = $clog2(NUM_CH);

    logic            req_valid;
    logic            req_ready;
    logic [CH_W-1:0] req_ch;
`ifdef SELFTRIG_TIMESTAMP_EN
    logic [TS_W-1:0] req_ts;

    modport master (output req_valid, output req_ch, output req_ts, input req_ready);
    modport slave  (input req_valid, input req_ch, input req_ts, output req_ready);
`else
    modport master (output req_valid, output req_ch, input req_ready);
    modport slave  (input req_valid, input req_ch, output req_ready);
`endif
endinterface

// File: rtl/selftrigger_channel_arbiter.sv
// Serialises CFD self-trigger edges from NUM_CH channels into one round-robin readout request stream.
// Optional: define SELFTRIG_TIMESTAMP_EN to latch and forward a per-trigger timestamp (req_ts).

module selftrigger_channel #(
    parameter int HOLDOFF = 512
`ifdef SELFTRIG_TIMESTAMP_EN
    ,parameter int TS_W = 64
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            trig_edge,
    input  logic            capture_en,
    input  logic            ch_en,
    input  logic            grant,
    input  logic            accept,
`ifdef SELFTRIG_TIMESTAMP_EN
    input  logic [TS_W-1:0] timestamp,
    output logic [TS_W-1:0] ts_q,
`endif
    output logic            pending,
    output logic            busy,
    output logic            drop
);
    localparam int HO_W = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_PENDING, ST_GRANTED, ST_HOLDOFF} state_t;
    state_t          state, state_nxt;
    logic [HO_W-1:0] hold_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_GRANTED && accept)
                hold_cnt <= HO_W'(HOLDOFF);
            else if (state == ST_HOLDOFF)
                hold_cnt <= hold_cnt - HO_W'(1);
        end
    end

    // Holdoff leaves on the cycle the count would reach zero, giving exactly HOLDOFF busy cycles.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:    if (trig_edge && capture_en) state_nxt = ST_PENDING;
            ST_PENDING: if (!ch_en) state_nxt = ST_IDLE;
                        else if (grant) state_nxt = ST_GRANTED;
            ST_GRANTED: if (accept) state_nxt = (HOLDOFF == 0) ? ST_IDLE : ST_HOLDOFF;
            ST_HOLDOFF: if (hold_cnt <= HO_W'(1)) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        pending = (state == ST_PENDING) && ch_en;
        busy    = (state != ST_IDLE);
        drop    = trig_edge && (state == ST_PENDING || state == ST_GRANTED);
    end

`ifdef SELFTRIG_TIMESTAMP_EN
    always_ff @(posedge clk) begin
        if (reset)
            ts_q <= '0;
        else if (state == ST_IDLE && state_nxt == ST_PENDING)
            ts_q <= timestamp;
    end
`endif
endmodule

module selftrigger_channel_arbiter #(
    parameter int NUM_CH  = 8,
    parameter int HOLDOFF = 512,
    parameter int CNT_W   = 16
`ifdef SELFTRIG_TIMESTAMP_EN
    ,parameter int TS_W   = 64
`endif
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [NUM_CH-1:0]            ch_enable,
    input  logic [NUM_CH-1:0]            trig_in,
    selftrigger_channel_arbiter_if.master req,
    output logic [NUM_CH-1:0]            busy,
    output logic [CNT_W-1:0]             overflow_count,
    input  logic                         clr_count
`ifdef SELFTRIG_TIMESTAMP_EN
    ,input logic [TS_W-1:0]              timestamp
`endif
);
    localparam int CH_W   = $clog2(NUM_CH);
    localparam int DROP_W = $clog2(NUM_CH + 1);
    localparam int SUM_W  = CNT_W + DROP_W;

    logic [NUM_CH-1:0] trig_q, trig_q2, trig_edge;
    logic [NUM_CH-1:0] pending, drop, grant, accept;
    logic [CH_W-1:0]   last_grant, sel, idx;
    logic              sel_found, accept_any, load_ok;
    logic [DROP_W-1:0] drop_n;
    logic [SUM_W-1:0]  cnt_sum;
`ifdef SELFTRIG_TIMESTAMP_EN
    logic [NUM_CH-1:0][TS_W-1:0] ch_ts;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            trig_q  <= '0;
            trig_q2 <= '0;
        end else begin
            trig_q  <= trig_in;
            trig_q2 <= trig_q;
        end
    end
    assign trig_edge = trig_q & ~trig_q2;

    assign accept_any = req.req_valid && req.req_ready;
    // Reload on the accept cycle too so back-to-back requests have no bubble.
    assign load_ok    = !req.req_valid || req.req_ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign grant[i]  = load_ok && sel_found && (sel == CH_W'(i));
        assign accept[i] = accept_any && (req.req_ch == CH_W'(i));

        selftrigger_channel #(
            .HOLDOFF (HOLDOFF)
`ifdef SELFTRIG_TIMESTAMP_EN
            ,.TS_W   (TS_W)
`endif
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .trig_edge  (trig_edge[i]),
            .capture_en (enable && ch_enable[i]),
            .ch_en      (ch_enable[i]),
            .grant      (grant[i]),
            .accept     (accept[i]),
`ifdef SELFTRIG_TIMESTAMP_EN
            .timestamp  (timestamp),
            .ts_q       (ch_ts[i]),
`endif
            .pending    (pending[i]),
            .busy       (busy[i]),
            .drop       (drop[i])
        );
    end

    // Round-robin: first pending channel after the last one granted, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel       = '0;
        idx       = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = CH_W'((int'(last_grant) + k) % NUM_CH);
            if (!sel_found && pending[idx]) begin
                sel_found = 1'b1;
                sel       = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req.req_valid <= 1'b0;
            req.req_ch    <= '0;
            last_grant    <= CH_W'(NUM_CH - 1);
`ifdef SELFTRIG_TIMESTAMP_EN
            req.req_ts    <= '0;
`endif
        end else if (load_ok) begin
            if (sel_found) begin
                req.req_valid <= 1'b1;
                req.req_ch    <= sel;
                last_grant    <= sel;
`ifdef SELFTRIG_TIMESTAMP_EN
                req.req_ts    <= ch_ts[sel];
`endif
            end else begin
                req.req_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        drop_n = '0;
        for (int i = 0; i < NUM_CH; i++)
            drop_n = drop_n + DROP_W'(drop[i]);
    end
    assign cnt_sum = SUM_W'(overflow_count) + SUM_W'(drop_n);

    always_ff @(posedge clk) begin
        if (reset || clr_count)
            overflow_count <= '0;
        else if (cnt_sum[SUM_W-1:CNT_W] != '0)
            overflow_count <= '1;
        else
            overflow_count <= cnt_sum[CNT_W-1:0];
    end
endmodule
